imem_responder: RTL and testbench

- Instruction-memory responder on the fetch request/response interface. It is the memory end that answers `if_stage`.
- Accepts one `if_req_t` request at a time, looks the address up in an internal word array, and returns one `if_resp_t` pulse after a fixed, configurable latency.
- A side load port fills the array (testbench or boot loader).
- Used in simulation tops and FPGA bring-up in place of a real cache/bus.

---
 rtl/imem_responder_if.sv | 33 +++
 rtl/imem_responder.sv | 119 +++++++++++
 tb/tb_imem_responder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Fetch request/response types and the bus between if_stage and memory.
// master: drives req_i, receives resp_o; slave: the memory side.
package imem_pkg;
  localparam int PHY_ADDR_LEN = 32;
  localparam logic [PHY_ADDR_LEN-1:0] PC_RESET_ADDR = 32'h8000_0000;

  typedef struct packed {
    logic                    valid;
    logic [PHY_ADDR_LEN-1:0] addr;
  } if_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } if_resp_t;
endpackage

interface imem_if;
  import imem_pkg::*;

  if_req_t  req_i;
  if_resp_t resp_o;

  modport master (
    output req_i,
    input  resp_o
  );

  modport slave (
    input  req_i,
    output resp_o
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch at a time, registered response
// pulse LATENCY cycles after accept. Ports: clk_i, rst_i, fetch (slave),
// load_we_i/load_idx_i/load_data_i side fill port, busy_o (FSM not idle).
module imem_responder
  import imem_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int DEPTH = 1024,
  parameter logic [PHY_ADDR_LEN-1:0] BASE_ADDR = PC_RESET_ADDR,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  imem_if.slave                    fetch,
  input  logic                     load_we_i,
  input  logic [$clog2(DEPTH)-1:0] load_idx_i,
  input  logic [31:0]              load_data_i,
  output logic                     busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [3:0] cnt;
  logic [3:0] cnt_nx;

  logic [PHY_ADDR_LEN-1:0] addr_q;
  logic [PHY_ADDR_LEN-1:0] addr_nx;
  logic [PHY_ADDR_LEN-1:0] offset;

  logic [AW-1:0] idx;
  logic          hit;

  logic [31:0] mem [DEPTH];

  if_resp_t resp_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = addr_q;
    unique case (state)
      IDLE: begin
        if (fetch.req_i.valid) begin
          addr_nx = fetch.req_i.addr;
          if (LATENCY == 1) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Decode from addr_nx so the LATENCY=1 path sees the address
  // being accepted on the same edge that enters RESP.
  always_comb begin
    offset = addr_nx - BASE_ADDR;
    idx    = offset[AW+1:2];
    hit    = (offset[1:0] == 2'b00)
          && ((offset >> 2) < PHY_ADDR_LEN'(DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      resp_q <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      addr_q <= addr_nx;
      resp_q.valid <= (state_nx == RESP);
      if (state_nx == RESP) begin
        resp_q.data <= hit ? mem[idx] : NOP;
      end else begin
        resp_q.data <= 32'd0;
      end
    end
  end

  // Read above sees the pre-edge word, so a same-edge write
  // returns old data.
  always_ff @(posedge clk_i) begin
    if (load_we_i && !rst_i) begin
      mem[load_idx_i] <= load_data_i;
    end
  end

  assign fetch.resp_o = resp_q;
  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with LATENCY 2, 1 and 15 instances.
// Expected data is queued on issue and popped when a pulse appears.
module tb_imem_responder;

  logic clk = 1'b0;
  logic rst;
  logic load_we;
  logic [3:0] load_idx;
  logic [31:0] load_data;
  logic busy0;
  logic busy1;
  logic busy2;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  imem_if bus0 ();
  imem_if bus1 ();
  imem_if bus2 ();

  imem_responder #(
    .LATENCY(2), .DEPTH(16), .BASE_ADDR(32'h1000), .INIT_FILE("")
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .fetch(bus0),
    .load_we_i(load_we), .load_idx_i(load_idx),
    .load_data_i(load_data), .busy_o(busy0)
  );

  imem_responder #(
    .LATENCY(1), .DEPTH(16), .BASE_ADDR(32'h1000), .INIT_FILE("")
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .fetch(bus1),
    .load_we_i(load_we), .load_idx_i(load_idx),
    .load_data_i(load_data), .busy_o(busy1)
  );

  imem_responder #(
    .LATENCY(15), .DEPTH(16), .BASE_ADDR(32'h1000), .INIT_FILE("")
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .fetch(bus2),
    .load_we_i(load_we), .load_idx_i(load_idx),
    .load_data_i(load_data), .busy_o(busy2)
  );

  function automatic logic get_valid(int s);
    case (s)
      0: return bus0.resp_o.valid;
      1: return bus1.resp_o.valid;
      default: return bus2.resp_o.valid;
    endcase
  endfunction

  function automatic logic [31:0] get_data(int s);
    case (s)
      0: return bus0.resp_o.data;
      1: return bus1.resp_o.data;
      default: return bus2.resp_o.data;
    endcase
  endfunction

  function automatic logic get_busy(int s);
    case (s)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  task automatic set_req(int s, logic v, logic [31:0] a);
    case (s)
      0: begin bus0.req_i.valid = v; bus0.req_i.addr = a; end
      1: begin bus1.req_i.valid = v; bus1.req_i.addr = a; end
      default: begin bus2.req_i.valid = v; bus2.req_i.addr = a; end
    endcase
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(int s, logic [31:0] a, logic [31:0] exp);
    set_req(s, 1'b1, a);
    sb.push_back(exp);
  endtask

  // mode 0: leave req alone, 1: drop valid, 2: random req until pulse
  task automatic wait_resp(string tag, int s, int cyc, int mode,
                           bit chk_busy);
    int got = 0;
    logic [31:0] d = '0;
    logic [31:0] e;
    for (int i = 1; i <= cyc + 2; i++) begin
      @(negedge clk);
      load_we = 1'b0;
      if (get_valid(s)) begin
        got = i;
        d = get_data(s);
        if (chk_busy) chk({tag, "_busy"}, 32'(get_busy(s)), 32'd1);
        break;
      end
      chk({tag, "_zero"}, get_data(s), 32'd0);
      if (chk_busy) chk({tag, "_busy"}, 32'(get_busy(s)), 32'd1);
      if (mode == 1) set_req(s, 1'b0, 32'd0);
      else if (mode == 2) set_req(s, 1'($urandom), $urandom);
    end
    if (mode != 0) set_req(s, 1'b0, 32'd0);
    chk({tag, "_lat"}, 32'(got), 32'(cyc));
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s_sb: observed pulse expected none", tag);
    end else begin
      e = sb.pop_front();
      if (got != 0) chk({tag, "_data"}, d, e);
    end
  endtask

  task automatic post_idle(string tag, int s);
    @(negedge clk);
    chk({tag, "_v"}, 32'(get_valid(s)), 32'd0);
    chk({tag, "_d"}, get_data(s), 32'd0);
    chk({tag, "_b"}, 32'(get_busy(s)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bad [3];
    bad[0] = 32'h1002;
    bad[1] = 32'h1040;
    bad[2] = 32'h0FFC;
    rst = 1'b1;
    load_we = 1'b0;
    load_idx = 4'd0;
    load_data = 32'd0;
    for (int s = 0; s < 3; s++) set_req(s, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst_v", 32'(get_valid(s)), 32'd0);
      chk("rst_d", get_data(s), 32'd0);
      chk("rst_b", 32'(get_busy(s)), 32'd0);
    end
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      load_we = 1'b1;
      load_idx = 4'(k);
      load_data = 32'hA000_0000 + 32'(k);
      @(negedge clk);
    end
    load_we = 1'b0;

    issue(0, 32'h1008, 32'hA000_0002);
    wait_resp("single", 0, 2, 1, 1'b1);
    post_idle("single_idle", 0);

    issue(0, 32'h1000, 32'hA000_0000);
    wait_resp("b2b0", 0, 2, 0, 1'b1);
    issue(0, 32'h1004, 32'hA000_0001);
    wait_resp("b2b1", 0, 3, 0, 1'b0);
    set_req(0, 1'b0, 32'd0);
    post_idle("b2b_idle", 0);

    for (int j = 0; j < 3; j++) begin
      issue(0, bad[j], 32'h0000_0013);
      wait_resp("invalid", 0, 2, 1, 1'b1);
      post_idle("invalid_idle", 0);
    end

    set_req(0, 1'b1, 32'h1004);
    @(negedge clk);
    chk("rstw_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    set_req(0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_b", 32'(busy0), 32'd0);
    chk("rstw_v", 32'(bus0.resp_o.valid), 32'd0);
    chk("rstw_d", bus0.resp_o.data, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rstw_nopulse", 32'(bus0.resp_o.valid), 32'd0);
    end
    issue(0, 32'h1004, 32'hA000_0001);
    wait_resp("rstw_read", 0, 2, 1, 1'b1);
    post_idle("rstw_idle", 0);

    issue(0, 32'h100C, 32'hA000_0003);
    @(negedge clk);
    load_we = 1'b1;
    load_idx = 4'd3;
    load_data = 32'hDEAD_BEEF;
    wait_resp("coll_old", 0, 1, 1, 1'b1);
    post_idle("coll_idle", 0);
    issue(0, 32'h100C, 32'hDEAD_BEEF);
    wait_resp("coll_new", 0, 2, 1, 1'b1);
    post_idle("coll_idle2", 0);

    issue(1, 32'h1004, 32'hA000_0001);
    wait_resp("lat1", 1, 1, 1, 1'b1);
    post_idle("lat1_idle", 1);

    issue(2, 32'h1004, 32'hA000_0001);
    wait_resp("lat15", 2, 15, 2, 1'b1);
    post_idle("lat15_idle", 2);
    post_idle("lat15_idle2", 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
